// File: rtl/n_bit_ripple_carry_adder.sv
// n_bit_ripple_carry_adder: N-bit ripple-carry adder with registered sum, carry-out and valid
module n_bit_ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  input  logic         in_valid,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         out_valid
);
  logic [N-1:0] s, sum_d, sum_q;
  logic         cy, cout_d, cout_q, out_valid_d, out_valid_q;
  always_comb begin
    s  = '0;
    cy = cin;
    for (int i = 0; i < N; i++) begin
      s[i] = A[i] ^ B[i] ^ cy;
      cy   = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
    end
    sum_d       = in_valid ? s : sum_q;
    cout_d      = in_valid ? cy : cout_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_n_bit_ripple_carry_adder.sv
// tb_n_bit_ripple_carry_adder: checks N=1, 8, 32 adders against an arithmetic reference model
module tb_n_bit_ripple_carry_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cin, in_valid;
  logic [0:0]  a1, b1, s1;
  logic [7:0]  a8, b8, s8;
  logic [31:0] a32, b32, s32;
  logic        c1, c8, c32, v1, v8, v32;
  logic [1:0]  e1;
  logic [8:0]  e8;
  logic [32:0] e32;
  logic        ev;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  n_bit_ripple_carry_adder #(.N(1)) d1 (.clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .cin(cin),
    .in_valid(in_valid), .sum(s1), .cout(c1), .out_valid(v1));
  n_bit_ripple_carry_adder #(.N(8)) d8 (.clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .cin(cin),
    .in_valid(in_valid), .sum(s8), .cout(c8), .out_valid(v8));
  n_bit_ripple_carry_adder #(.N(32)) d32 (.clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .cin(cin),
    .in_valid(in_valid), .sum(s32), .cout(c32), .out_valid(v32));
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e1  <= '0;
      e8  <= '0;
      e32 <= '0;
      ev  <= 1'b0;
    end else begin
      if (in_valid) begin
        e1  <= 2'(a1) + 2'(b1) + 2'(cin);
        e8  <= 9'(a8) + 9'(b8) + 9'(cin);
        e32 <= 33'(a32) + 33'(b32) + 33'(cin);
      end
      ev <= in_valid;
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("n1", 64'({c1, s1, v1}), 64'({e1, ev}));
    chk("n8", 64'({c8, s8, v8}), 64'({e8, ev}));
    chk("n32", 64'({c32, s32, v32}), 64'({e32, ev}));
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    a8 = a;
    b8 = b;
    cin = c;
    in_valid = v;
    a1 = 1'($urandom);
    b1 = 1'($urandom);
    a32 = $urandom;
    b32 = $urandom;
  endtask
  task automatic lit(input string name, input logic [7:0] s, input logic c, input logic v);
    chk(name, 64'({c8, s8, v8}), 64'({c, s, v}));
    chk({name, "_model"}, 64'({e8, ev}), 64'({c, s, v}));
  endtask
  initial begin
    rst_n = 1'b1;
    put(8'h00, 8'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    put(8'hFF, 8'hFF, 1'b1, 1'b1);
    cyc;
    cyc;
    lit("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    put(8'h03, 8'h57, 1'b1, 1'b1); cyc; lit("basic", 8'h5B, 1'b0, 1'b1);
    put(8'h2B, 8'h31, 1'b1, 1'b1); cyc; lit("b2b_1", 8'h5D, 1'b0, 1'b1);
    put(8'h80, 8'h41, 1'b1, 1'b1); cyc; lit("b2b_2", 8'hC2, 1'b0, 1'b1);
    put(8'hFF, 8'h00, 1'b1, 1'b1); cyc; lit("ones_zero_c1", 8'h00, 1'b1, 1'b1);
    put(8'hFF, 8'hFF, 1'b1, 1'b1); cyc; lit("ones_ones_c1", 8'hFF, 1'b1, 1'b1);
    put(8'hFF, 8'h00, 1'b0, 1'b1); cyc; lit("ones_zero_c0", 8'hFF, 1'b0, 1'b1);
    put(8'h79, 8'h62, 1'b1, 1'b1); cyc; lit("hold_load", 8'hDC, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      put(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      if (i == 1) begin
        a8 = 'x;
        b8 = 'x;
      end
      cyc;
      lit("hold", 8'hDC, 1'b0, 1'b0);
    end
    put(8'h03, 8'h57, 1'b1, 1'b1); cyc; lit("pre_reset", 8'h5B, 1'b0, 1'b1);
    put(8'h10, 8'h20, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 lit("async_reset", 8'h00, 1'b0, 1'b0);
    cyc;
    lit("reset_held", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    put(8'h01, 8'h01, 1'b0, 1'b0); cyc; lit("post_reset_idle", 8'h00, 1'b0, 1'b0);
    put(8'h01, 8'h01, 1'b0, 1'b1); cyc; lit("post_reset_first", 8'h02, 1'b0, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      put(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 9) < 8);
      cyc;
    end
    in_valid = 1'b0;
    cyc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
